mc_ctrl_sequencer: RTL and testbench
====================================

Name: mc_ctrl_sequencer

Overview:
- Full control sequencer for the multi-cycle MIPS-subset processor. It replaces the combinational dispatch lookup with a registered state machine covering fetch (with memory wait), decode dispatch, per-instruction execute/writeback, and a multi-cycle multiply.
- Adds illegal-instruction handling, selectable by mode, and a retired-instruction counter.
- Sits between the instruction register (op/funct) and the datapath strobes.

Parameters:
- STATE_W, 8, width of o_state (min 5); state codes zero-extended.
- MUL_LAT, 32, cycles spent in MULT_WAIT (1..255).
- TRAP_EN, 1, 1 = illegal instruction goes to TRAP and halts; 0 = illegal treated as NOP, return to FETCH.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_op  in  6  instruction opcode from IR.
- i_funct  in  6  funct field from IR.
- i_mem_ready  in  1  instruction memory data valid.
- o_state  out  STATE_W  current state code.
- o_ir_write  out  1  load IR.
- o_pc_write  out  1  unconditional PC load.
- o_branch  out  1  conditional PC load (datapath evaluates condition).
- o_reg_write  out  1  register-file write.
- o_mul_start  out  1  one-cycle multiplier start pulse.
- o_hilo_write  out  1  HI/LO load.
- o_instr_done  out  1  one-cycle pulse in last state of each instruction.
- o_trap  out  1  high while in TRAP.
- o_retired  out  CNT_W  count of o_instr_done pulses.

Behaviour:
- State register, reset-only asynchronous. i_rst_n low -> state=FETCH(0), mul counter=0, o_retired=0. All strobes forced 0 while i_rst_n low. Reset mid-instruction (including mid-MULT_WAIT) abandons the instruction; no done pulse.
- Outputs are combinational decodes of state (Moore). Exception: FETCH strobes are qualified by i_mem_ready.
- FETCH(0): o_ir_write=o_pc_write=i_mem_ready. Holds while i_mem_ready=0. Goes to DECODE(1) on i_mem_ready=1.
- DECODE(1), no strobes. Dispatch on op=0 by funct:
  - jr 001000 -> 24
  - srav 000111 -> 2
  - mflo 010010 -> 22
  - mult 011000 -> 20
  - nor 100111 -> 6
  - slt 101010 -> 10
- DECODE dispatch on op:
  - jal 000011 -> 18
  - beq 000100 -> 14
  - bgtz 000111 -> 16
  - addi 001000 -> 4
  - slti 001010 -> 12
  - xori 001110 -> 8
- Anything else in DECODE -> ILLEGAL(26).
- Two-state ALU ops: srav 2->3, addi 4->5, nor 6->7, xori 8->9, slt 10->11, slti 12->13.
  - Even state executes, no strobes.
  - Odd state asserts o_reg_write and o_instr_done, then -> FETCH.
- beq 14, bgtz 16: o_branch=1, o_instr_done=1, -> FETCH.
- jal: 18 asserts o_reg_write (link), -> 19. 19 asserts o_pc_write and o_instr_done, -> FETCH.
- jr 24: o_pc_write, o_instr_done, -> FETCH.
- mult:
  - 20 MULT_START: o_mul_start=1, counter loaded MUL_LAT-1, -> 21.
  - 21 MULT_WAIT: counter decrements each cycle. When counter==0: o_hilo_write=1, o_instr_done=1, -> FETCH.
  - Exactly MUL_LAT cycles in state 21.
- mflo: 22 -> 23. State 23 asserts o_reg_write and o_instr_done.
- ILLEGAL(26), one cycle, no done pulse, counter not incremented.
  - TRAP_EN=1 -> TRAP(27).
  - TRAP_EN=0 -> FETCH.
- TRAP(27): o_trap=1, absorbing; exits only via reset.
- Any unlisted state code -> FETCH next cycle. Outputs in unlisted codes are 0.
- o_retired increments on each o_instr_done cycle and wraps 2^CNT_W-1 -> 0.
- Latency, excluding memory wait: branch/jr 3 cycles; ALU/jal/mflo 4 cycles; mult 3+MUL_LAT cycles.

Test Plan:
- Reset held low 3 cycles with i_mem_ready=1 -> all strobes 0, o_state=0, o_retired=0. Release -> o_ir_write=o_pc_write=1 same cycle, o_state=1 next cycle.
- addi (op=001000), i_mem_ready delayed 4 cycles -> FETCH held 5 cycles, then states 1,4,5. o_reg_write and o_instr_done high only in 5. o_retired=1.
- mult (op=0, funct=011000), MUL_LAT=4 -> states 0,1,20,21,21,21,21,0. o_mul_start once; o_hilo_write and o_instr_done only in the 4th state-21 cycle.
- op=111111, TRAP_EN=1 -> states 1,26,27 and stays in 27; o_trap=1; o_retired unchanged. Repeat with TRAP_EN=0 -> 26 then 0.
- Reset asserted during 2nd MULT_WAIT cycle -> o_state=0 asynchronously; no o_hilo_write, no done pulse; o_retired unchanged.
- CNT_W=4, run 17 beq instructions -> o_retired sequence reaches 15, wraps to 0, ends at 1.

Source files
------------

// File: rtl/mc_ctrl_sequencer_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_sequencer_if
// Bundles the instruction-register fields, the memory-ready handshake and the
// datapath strobes that pass between the control sequencer and the datapath.
//   i_op, i_funct   : opcode / funct fields from the instruction register
//   i_mem_ready     : instruction memory data valid
//   o_state         : current sequencer state code (zero-extended)
//   o_ir_write ..   : datapath strobes (IR load, PC load, branch, reg write,
//                     multiplier start, HI/LO load)
//   o_instr_done    : one-cycle pulse in the final state of each instruction
//   o_trap          : high while the sequencer is halted in TRAP
//   o_retired       : count of completed instructions (wraps)
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mc_ctrl_sequencer_if #(
  parameter int STATE_W = 8,
  parameter int CNT_W   = 16
);
  logic [5:0]         i_op;
  logic [5:0]         i_funct;
  logic               i_mem_ready;
  logic [STATE_W-1:0] o_state;
  logic               o_ir_write;
  logic               o_pc_write;
  logic               o_branch;
  logic               o_reg_write;
  logic               o_mul_start;
  logic               o_hilo_write;
  logic               o_instr_done;
  logic               o_trap;
  logic [CNT_W-1:0]   o_retired;

  modport master (
    input  i_op, i_funct, i_mem_ready,
    output o_state, o_ir_write, o_pc_write, o_branch, o_reg_write,
           o_mul_start, o_hilo_write, o_instr_done, o_trap, o_retired
  );

  modport slave (
    output i_op, i_funct, i_mem_ready,
    input  o_state, o_ir_write, o_pc_write, o_branch, o_reg_write,
           o_mul_start, o_hilo_write, o_instr_done, o_trap, o_retired
  );
endinterface

// File: rtl/mc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// mc_ctrl_sequencer
// Registered control state machine for the multi-cycle MIPS-subset processor:
// fetch with memory wait, decode dispatch, per-instruction execute/writeback,
// a multi-cycle multiply, illegal-instruction handling and a retired counter.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : mc_ctrl_sequencer_if.master (IR fields in, strobes/state out)
// Outputs are Moore decodes of the state, except that the FETCH strobes are
// qualified by i_mem_ready. All strobes are held low while i_rst_n is low.
// -----------------------------------------------------------------------------
module mc_ctrl_sequencer #(
  parameter int STATE_W = 8,   // width of o_state, at least 5
  parameter int MUL_LAT = 32,  // cycles spent in MULT_WAIT, 1..255
  parameter bit TRAP_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mc_ctrl_sequencer_if.master  bus
);

  typedef enum logic [4:0] {
    S_FETCH      = 5'd0,
    S_DECODE     = 5'd1,
    S_SRAV_EX    = 5'd2,
    S_SRAV_WB    = 5'd3,
    S_ADDI_EX    = 5'd4,
    S_ADDI_WB    = 5'd5,
    S_NOR_EX     = 5'd6,
    S_NOR_WB     = 5'd7,
    S_XORI_EX    = 5'd8,
    S_XORI_WB    = 5'd9,
    S_SLT_EX     = 5'd10,
    S_SLT_WB     = 5'd11,
    S_SLTI_EX    = 5'd12,
    S_SLTI_WB    = 5'd13,
    S_BEQ        = 5'd14,
    S_BGTZ       = 5'd16,
    S_JAL_LINK   = 5'd18,
    S_JAL_JUMP   = 5'd19,
    S_MULT_START = 5'd20,
    S_MULT_WAIT  = 5'd21,
    S_MFLO_EX    = 5'd22,
    S_MFLO_WB    = 5'd23,
    S_JR         = 5'd24,
    S_ILLEGAL    = 5'd26,
    S_TRAP       = 5'd27
  } state_t;

  state_t           state, state_next;
  logic [7:0]       mul_cnt, mul_cnt_next;
  logic [CNT_W-1:0] retired;

  logic ir_write, pc_write, branch, reg_write;
  logic mul_start, hilo_write, instr_done, trap;

  // Decode dispatch: R-type (op 0) selects by funct, everything else by op.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
    dispatch = S_ILLEGAL;
    if (op == 6'b000000) begin
      case (funct)
        6'b001000: dispatch = S_JR;
        6'b000111: dispatch = S_SRAV_EX;
        6'b010010: dispatch = S_MFLO_EX;
        6'b011000: dispatch = S_MULT_START;
        6'b100111: dispatch = S_NOR_EX;
        6'b101010: dispatch = S_SLT_EX;
        default:   dispatch = S_ILLEGAL;
      endcase
    end else begin
      case (op)
        6'b000011: dispatch = S_JAL_LINK;
        6'b000100: dispatch = S_BEQ;
        6'b000111: dispatch = S_BGTZ;
        6'b001000: dispatch = S_ADDI_EX;
        6'b001010: dispatch = S_SLTI_EX;
        6'b001110: dispatch = S_XORI_EX;
        default:   dispatch = S_ILLEGAL;
      endcase
    end
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_FETCH;
      mul_cnt <= '0;
      retired <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = S_FETCH;
    mul_cnt_next = mul_cnt;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    reg_write    = 1'b0;
    mul_start    = 1'b0;
    hilo_write   = 1'b0;
    instr_done   = 1'b0;
    trap         = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = bus.i_mem_ready;
        pc_write   = bus.i_mem_ready;
        state_next = bus.i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE:    state_next = dispatch(bus.i_op, bus.i_funct);
      S_SRAV_EX:   state_next = S_SRAV_WB;
      S_ADDI_EX:   state_next = S_ADDI_WB;
      S_NOR_EX:    state_next = S_NOR_WB;
      S_XORI_EX:   state_next = S_XORI_WB;
      S_SLT_EX:    state_next = S_SLT_WB;
      S_SLTI_EX:   state_next = S_SLTI_WB;
      S_MFLO_EX:   state_next = S_MFLO_WB;
      S_SRAV_WB, S_ADDI_WB, S_NOR_WB, S_XORI_WB,
      S_SLT_WB, S_SLTI_WB, S_MFLO_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BGTZ: begin
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL_LINK: begin
        reg_write  = 1'b1;
        state_next = S_JAL_JUMP;
      end
      S_JAL_JUMP, S_JR: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_MULT_START: begin
        mul_start    = 1'b1;
        mul_cnt_next = 8'(MUL_LAT - 1);
        state_next   = S_MULT_WAIT;
      end
      // Counter reaching zero marks the MUL_LAT-th cycle spent in this state.
      S_MULT_WAIT: begin
        if (mul_cnt == 8'd0) begin
          hilo_write = 1'b1;
          instr_done = 1'b1;
        end else begin
          mul_cnt_next = mul_cnt - 8'd1;
          state_next   = S_MULT_WAIT;
        end
      end
      S_ILLEGAL:   state_next = TRAP_EN ? S_TRAP : S_FETCH;
      S_TRAP: begin
        trap       = 1'b1;
        state_next = S_TRAP;
      end
      default:     state_next = S_FETCH;
    endcase
  end

  // During reset the state is already FETCH, but FETCH strobes follow
  // i_mem_ready, so the reset level gates every strobe explicitly.
  assign bus.o_state      = STATE_W'(state);
  assign bus.o_ir_write   = ir_write   & i_rst_n;
  assign bus.o_pc_write   = pc_write   & i_rst_n;
  assign bus.o_branch     = branch     & i_rst_n;
  assign bus.o_reg_write  = reg_write  & i_rst_n;
  assign bus.o_mul_start  = mul_start  & i_rst_n;
  assign bus.o_hilo_write = hilo_write & i_rst_n;
  assign bus.o_instr_done = instr_done & i_rst_n;
  assign bus.o_trap       = trap       & i_rst_n;
  assign bus.o_retired    = retired;

endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_sequencer
// Two sequencer instances share clock and reset:
//   dut_a : MUL_LAT=4,  TRAP_EN=1, CNT_W=4
//   dut_b : MUL_LAT=32, TRAP_EN=0, CNT_W=16
// Only the instance under test sees i_mem_ready=1; the other idles in FETCH.
// Expected per-cycle states and strobes come from an instruction-level model
// that lists the state walk each instruction class produces.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_sequencer;

  localparam int A_MUL = 4;
  localparam int B_MUL = 32;

  // Strobe vector bit positions used by the model and the sampler.
  localparam logic [7:0] B_IR = 8'h01;
  localparam logic [7:0] B_PC = 8'h02;
  localparam logic [7:0] B_BR = 8'h04;
  localparam logic [7:0] B_RW = 8'h08;
  localparam logic [7:0] B_MS = 8'h10;
  localparam logic [7:0] B_HL = 8'h20;
  localparam logic [7:0] B_DN = 8'h40;
  localparam logic [7:0] B_TR = 8'h80;

  typedef struct {
    int         st;
    logic [7:0] sb;
  } step_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_sequencer_if #(.STATE_W(8), .CNT_W(4))  bus_a ();
  mc_ctrl_sequencer_if #(.STATE_W(8), .CNT_W(16)) bus_b ();

  mc_ctrl_sequencer #(.STATE_W(8), .MUL_LAT(A_MUL), .TRAP_EN(1'b1), .CNT_W(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a)
  );
  mc_ctrl_sequencer #(.STATE_W(8), .MUL_LAT(B_MUL), .TRAP_EN(1'b0), .CNT_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b)
  );

  int    n_checks = 0;
  int    n_err    = 0;
  step_t exp_q[$];
  int    ret_model[2];
  int    ret_mod[2] = '{16, 65536};

  logic [5:0] leg_op[12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b000011, 6'b000100, 6'b000111, 6'b001000, 6'b001010, 6'b001110};
  logic [5:0] leg_fn[6]  = '{6'b001000, 6'b000111, 6'b010010, 6'b011000, 6'b100111, 6'b101010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [31:0] st, output logic [7:0] sb,
                        output logic [31:0] ret);
    if (sel == 0) begin
      st  = {24'b0, bus_a.o_state};
      sb  = {bus_a.o_trap, bus_a.o_instr_done, bus_a.o_hilo_write, bus_a.o_mul_start,
             bus_a.o_reg_write, bus_a.o_branch, bus_a.o_pc_write, bus_a.o_ir_write};
      ret = {28'b0, bus_a.o_retired};
    end else begin
      st  = {24'b0, bus_b.o_state};
      sb  = {bus_b.o_trap, bus_b.o_instr_done, bus_b.o_hilo_write, bus_b.o_mul_start,
             bus_b.o_reg_write, bus_b.o_branch, bus_b.o_pc_write, bus_b.o_ir_write};
      ret = {16'b0, bus_b.o_retired};
    end
  endtask

  // Compare one DUT against an explicit state/strobe/counter expectation.
  task automatic expect_now(input int sel, input string tag, input int st, input logic [7:0] sb);
    logic [31:0] g_st, g_ret;
    logic [7:0]  g_sb;
    sample(sel, g_st, g_sb, g_ret);
    check($sformatf("%s.%0d state", tag, sel), g_st, st);
    check($sformatf("%s.%0d strobes", tag, sel), {24'b0, g_sb}, {24'b0, sb});
    check($sformatf("%s.%0d retired", tag, sel), g_ret, ret_model[sel]);
  endtask

  function automatic void push(input int st, input logic [7:0] sb);
    step_t s;
    s.st = st;
    s.sb = sb;
    exp_q.push_back(s);
  endfunction

  // Instruction-level model: the states visited after FETCH and their strobes.
  function automatic void build_expect(input logic [5:0] op, input logic [5:0] funct,
                                       input int mul_lat, input bit trap_en);
    int ex;
    bit illegal;
    ex = -1;
    illegal = 1'b0;
    push(1, 8'h00);
    if (op == 6'b000000) begin
      case (funct)
        6'b001000: push(24, B_PC | B_DN);
        6'b000111: ex = 2;
        6'b100111: ex = 6;
        6'b101010: ex = 10;
        6'b010010: begin push(22, 8'h00); push(23, B_RW | B_DN); end
        6'b011000: begin
          push(20, B_MS);
          for (int i = 0; i < mul_lat - 1; i++) push(21, 8'h00);
          push(21, B_HL | B_DN);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (op)
        6'b000011: begin push(18, B_RW); push(19, B_PC | B_DN); end
        6'b000100: push(14, B_BR | B_DN);
        6'b000111: push(16, B_BR | B_DN);
        6'b001000: ex = 4;
        6'b001010: ex = 12;
        6'b001110: ex = 8;
        default:   illegal = 1'b1;
      endcase
    end
    if (ex >= 0) begin
      push(ex, 8'h00);
      push(ex + 1, B_RW | B_DN);
    end
    if (illegal) begin
      push(26, 8'h00);
      if (trap_en) push(27, B_TR);
    end
  endfunction

  task automatic set_inputs(input int sel, input logic [5:0] op, input logic [5:0] funct,
                            input logic rdy);
    if (sel == 0) begin
      bus_a.i_op = op; bus_a.i_funct = funct; bus_a.i_mem_ready = rdy;
    end else begin
      bus_b.i_op = op; bus_b.i_funct = funct; bus_b.i_mem_ready = rdy;
    end
  endtask

  // Walk the model queue one cycle per entry, sampling at the falling edge.
  task automatic check_seq(input int sel, input string tag);
    step_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      expect_now(sel, tag, e.st, e.sb);
      if ((e.sb & B_DN) != 8'h00) ret_model[sel] = (ret_model[sel] + 1) % ret_mod[sel];
      @(posedge clk); #1;
    end
  endtask

  // FETCH with a memory wait, then the instruction body.
  task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] funct,
                           input int wait_cyc, input string tag);
    set_inputs(sel, op, funct, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      expect_now(sel, {tag, ".wait"}, 0, 8'h00);
      @(posedge clk); #1;
    end
    set_inputs(sel, op, funct, 1'b1);
    @(negedge clk);
    expect_now(sel, {tag, ".fetch"}, 0, B_IR | B_PC);
    @(posedge clk); #1;
    set_inputs(sel, op, funct, 1'b0);
    build_expect(op, funct, (sel == 0) ? A_MUL : B_MUL, sel == 0);
    check_seq(sel, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ret_model[0] = 0;
    ret_model[1] = 0;
    repeat (2) begin
      @(negedge clk);
      expect_now(0, "rst", 0, 8'h00);
      expect_now(1, "rst", 0, 8'h00);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op, fn;
    int sel;
    ret_model[0] = 0;
    ret_model[1] = 0;
    set_inputs(1, 6'b0, 6'b0, 1'b0);

    // Reset held 3 cycles with memory ready: strobes gated, counters clear.
    set_inputs(0, 6'b001000, 6'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      expect_now(0, "por", 0, 8'h00);
      expect_now(1, "por", 0, 8'h00);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    expect_now(0, "release", 0, B_IR | B_PC);
    @(posedge clk); #1;
    set_inputs(0, 6'b001000, 6'b0, 1'b0);
    build_expect(6'b001000, 6'b0, A_MUL, 1'b1);
    check_seq(0, "addi0");

    // addi with a 4-cycle memory wait, then mult with MUL_LAT=4.
    run_instr(0, 6'b001000, 6'b0, 4, "addi_wait");
    run_instr(0, 6'b000000, 6'b011000, 0, "mult_a");

    // Randomized legal instructions on dut_a, any encoding on dut_b.
    for (int i = 0; i < 14; i++) begin
      sel = i % 2;
      op = leg_op[$urandom_range(0, 11)];
      fn = (op == 6'b000000) ? leg_fn[$urandom_range(0, 5)] : 6'($urandom);
      if (sel == 1 && $urandom_range(0, 3) == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(sel, op, fn, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Illegal encoding without trap: 26 then back to FETCH.
    run_instr(1, 6'b111111, 6'b000000, 0, "ill_b");
    @(negedge clk);
    expect_now(1, "ill_b.back", 0, 8'h00);
    @(posedge clk); #1;

    // Reset during the second MULT_WAIT cycle abandons the multiply.
    do_reset();
    set_inputs(0, 6'b000000, 6'b011000, 1'b1);
    @(negedge clk);
    expect_now(0, "mrst.fetch", 0, B_IR | B_PC);
    @(posedge clk); #1;
    set_inputs(0, 6'b000000, 6'b011000, 1'b0);
    push(1, 8'h00); push(20, B_MS); push(21, 8'h00);
    check_seq(0, "mrst");
    #1;
    expect_now(0, "mrst.wait2", 21, 8'h00);
    rst_n = 1'b0;
    #1;
    expect_now(0, "mrst.async", 0, 8'h00);
    repeat (3) begin
      @(negedge clk);
      expect_now(0, "mrst.hold", 0, 8'h00);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    expect_now(0, "mrst.idle", 0, 8'h00);
    @(posedge clk); #1;

    // 17 branches on the 4-bit counter: 15 -> 0 -> 1.
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(0, 6'b000100, 6'($urandom), 0, $sformatf("beq%0d", i));
    @(negedge clk);
    check("wrap final", {28'b0, bus_a.o_retired}, 32'd1);
    @(posedge clk); #1;

    // Illegal with trap enabled: 26, then absorbing TRAP even with memory ready.
    run_instr(0, 6'b111111, 6'b101010, 0, "trap");
    set_inputs(0, 6'b001000, 6'b0, 1'b1);
    repeat (4) push(27, B_TR);
    check_seq(0, "trap.hold");

    do_reset();
    @(negedge clk);
    expect_now(0, "final", 0, B_IR | B_PC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
